// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD sequencer: command-word layout,
// HD44780 instruction codes, FSM state encodings and command-word builders.
package lcd_pkg;

  localparam int CMD_W   = 11;
  localparam int CMD_SEL = 10;
  localparam int CMD_RS  = 9;
  localparam int CMD_RW  = 8;

  localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
  localparam logic [7:0] DISP_ON       = 8'h0C;
  localparam logic [7:0] CLR           = 8'h01;
  localparam logic [7:0] ENTRY_INC     = 8'h06;
  localparam logic [7:0] SET_DDRAM     = 8'h80;

  localparam logic [2:0] ST_PWR_WAIT = 3'd0;
  localparam logic [2:0] ST_INIT     = 3'd1;
  localparam logic [2:0] ST_IDLE     = 3'd2;
  localparam logic [2:0] ST_CLEAR    = 3'd3;
  localparam logic [2:0] ST_ADDR     = 3'd4;
  localparam logic [2:0] ST_DATA     = 3'd5;

  localparam logic [2:0] ROM_END = 3'd4;

  function automatic logic [CMD_W-1:0] instr_word(input logic [7:0] instr);
    logic [CMD_W-1:0] w;
    w      = '0;
    w[7:0] = instr;
    return w;
  endfunction

  function automatic logic [CMD_W-1:0] slot_word(input logic [7:0] k);
    logic [CMD_W-1:0] w;
    w          = '0;
    w[CMD_SEL] = 1'b1;
    w[CMD_RS]  = 1'b1;
    w[CMD_RW]  = 1'b0;
    w[7:0]     = k;
    return w;
  endfunction

  function automatic logic [7:0] init_instr(input logic [1:0] idx);
    logic [7:0] v;
    case (idx)
      2'd0:    v = FUNC_SET_8B2L;
      2'd1:    v = DISP_ON;
      2'd2:    v = CLR;
      2'd3:    v = ENTRY_INC;
      default: v = FUNC_SET_8B2L;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Saturating down-counter used for every controller timing wait;
// o_done is high while the count sits at zero.
module wait_timer #(
  parameter int unsigned      CNT_W   = 19,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: a load wins, otherwise count down and hold at zero.
  always_comb begin
    if (i_load) begin
      cnt_d = i_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_done = (cnt_q == '0);

endmodule

// File: rtl/lcd_sequencer.sv
// Character-LCD command sequencer: HD44780 power-on init, then clear and
// screen-refresh command streams with the controller's timing waits.
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned SIZE      = 4,
  parameter logic [6:0]  ADDR_BASE = 7'h00,
  parameter int unsigned T_PWR     = 375000,
  parameter int unsigned T_CMD     = 1000,
  parameter int unsigned T_CLR     = 41000,
  parameter int unsigned CNT_W     = 19
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_update,
  input  logic             i_clear,
  output logic [CMD_W-1:0] o_comm,
  output logic             o_strobe,
  output logic             o_busy,
  output logic             o_init_done
);

  localparam int unsigned       SLOT_W    = $clog2(SIZE + 1);
  localparam logic [CNT_W-1:0]  W_PWR     = CNT_W'(T_PWR);
  localparam logic [CNT_W-1:0]  W_CMD     = CNT_W'(T_CMD);
  localparam logic [CNT_W-1:0]  W_CLR     = CNT_W'(T_CLR);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] SLOT_END  = SLOT_W'(SIZE);
  localparam logic [CMD_W-1:0]  ADDR_WORD = instr_word(SET_DDRAM | {1'b0, ADDR_BASE});

  logic [2:0]        state_q, state_d;
  logic [2:0]        rom_idx_q, rom_idx_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              upd_pend_q, upd_pend_d;
  logic              clr_pend_q, clr_pend_d;
  logic [CMD_W-1:0]  comm_q, comm_d;
  logic              strobe_q, strobe_d;
  logic              busy_q, busy_d;
  logic              init_done_q, init_done_d;

  logic              timer_load_s;
  logic [CNT_W-1:0]  timer_val_s;
  logic              timer_done_s;
  logic              dispatch_s;
  logic              take_clr_s;
  logic              take_upd_s;

  wait_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (W_PWR)
  ) u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (timer_load_s),
    .i_val  (timer_val_s),
    .o_done (timer_done_s)
  );

  // Next-state, command issue and request bookkeeping.
  always_comb begin
    state_d      = state_q;
    rom_idx_d    = rom_idx_q;
    slot_d       = slot_q;
    comm_d       = comm_q;
    strobe_d     = 1'b0;
    init_done_d  = init_done_q;
    timer_load_s = 1'b0;
    timer_val_s  = W_CMD;
    dispatch_s   = 1'b0;

    case (state_q)
      // The power-on wait ends by issuing ROM[0], so both states share the ROM walk.
      ST_PWR_WAIT, ST_INIT: begin
        if (timer_done_s && (rom_idx_q == ROM_END)) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end else if (timer_done_s) begin
          comm_d       = instr_word(init_instr(rom_idx_q[1:0]));
          strobe_d     = 1'b1;
          timer_load_s = 1'b1;
          timer_val_s  = (init_instr(rom_idx_q[1:0]) == CLR) ? W_CLR : W_CMD;
          rom_idx_d    = rom_idx_q + 3'd1;
          state_d      = ST_INIT;
        end else begin
          state_d = state_q;
        end
      end
      ST_IDLE:  dispatch_s = 1'b1;
      ST_CLEAR: dispatch_s = timer_done_s;
      ST_ADDR: begin
        if (timer_done_s) begin
          comm_d       = slot_word(8'd0);
          strobe_d     = 1'b1;
          timer_load_s = 1'b1;
          slot_d       = SLOT_ONE;
          state_d      = ST_DATA;
        end else begin
          state_d = state_q;
        end
      end
      ST_DATA: begin
        if (timer_done_s && (slot_q == SLOT_END)) begin
          dispatch_s = 1'b1;
        end else if (timer_done_s) begin
          comm_d       = slot_word(8'(slot_q));
          strobe_d     = 1'b1;
          timer_load_s = 1'b1;
          slot_d       = slot_q + SLOT_ONE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_PWR_WAIT;
    endcase

    // Finished sequences chain straight into pending work so no wait cycle is lost.
    take_clr_s = dispatch_s & clr_pend_q;
    take_upd_s = dispatch_s & ~clr_pend_q & upd_pend_q;
    if (take_clr_s) begin
      comm_d       = instr_word(CLR);
      strobe_d     = 1'b1;
      timer_load_s = 1'b1;
      timer_val_s  = W_CLR;
      state_d      = ST_CLEAR;
    end else if (take_upd_s) begin
      comm_d       = ADDR_WORD;
      strobe_d     = 1'b1;
      timer_load_s = 1'b1;
      timer_val_s  = W_CMD;
      state_d      = ST_ADDR;
    end else if (dispatch_s) begin
      state_d = ST_IDLE;
    end else begin
      dispatch_s = 1'b0;
    end

    upd_pend_d = (upd_pend_q & ~take_upd_s) | i_update;
    clr_pend_d = (clr_pend_q & ~take_clr_s) | i_clear;
    busy_d     = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_PWR_WAIT;
      rom_idx_q   <= 3'd0;
      slot_q      <= '0;
      upd_pend_q  <= 1'b0;
      clr_pend_q  <= 1'b0;
      comm_q      <= '0;
      strobe_q    <= 1'b0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_idx_q   <= rom_idx_d;
      slot_q      <= slot_d;
      upd_pend_q  <= upd_pend_d;
      clr_pend_q  <= clr_pend_d;
      comm_q      <= comm_d;
      strobe_q    <= strobe_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
    end
  end

  assign o_comm      = comm_q;
  assign o_strobe    = strobe_q;
  assign o_busy      = busy_q;
  assign o_init_done = init_done_q;

endmodule
